n101_uart_tx: RTL and testbench



---
 rtl/n101_uart_pkg.sv | 25 ++
 rtl/n101_uart_baud_cnt.sv | 42 ++++
 rtl/n101_uart_tx.sv | 83 ++++++++
 tb/tb_n101_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n101_uart_pkg.sv
// Shared definitions for the n101 UART blocks: state encoding, frame lengths and
// default widths.
package n101_uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_DIV_W  = 16;

  // Frame length in bit periods: start + 8 data + stop bit(s).
  localparam logic [3:0] UART_FRAME_1STOP = 4'd10;
  localparam logic [3:0] UART_FRAME_2STOP = 4'd11;

  localparam logic UART_IDLE  = 1'b0;
  localparam logic UART_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = UART_IDLE,
    StShift = UART_SHIFT
  } uart_state_e;

  // Number of bit periods in a frame for the selected stop-bit count.
  function automatic logic [3:0] uart_frame_len(input logic nstop);
    return nstop ? UART_FRAME_2STOP : UART_FRAME_1STOP;
  endfunction

endpackage

// File: rtl/n101_uart_baud_cnt.sv
// Loadable baud down-counter. Ticks on the last cycle of each bit period and
// reloads itself from reload_val so consecutive bits need no extra load.
module n101_uart_baud_cnt #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = run & (cnt_q == '0);

  // Next count: explicit load wins, otherwise count down and wrap to the reload value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = reload_val;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/n101_uart_tx.sv
// UART transmit serializer. Pops one byte per frame from the TX queue and
// shifts out an 8N1/8N2 frame, LSB first, at io_div+1 clocks per bit.
module n101_uart_tx
  import n101_uart_pkg::*;
#(
  parameter int unsigned DIV_W  = UART_DIV_W,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_en,
  input  logic [DIV_W-1:0]  io_div,
  input  logic              io_nstop,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  output logic              io_txd,
  output logic              io_busy
);

  localparam int unsigned ShiftW = DATA_W + 3;

  uart_state_e       state_q;
  logic [ShiftW-1:0] shift_q;
  logic [3:0]        bitcnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              accept;
  logic              bit_tick;

  // Ready is gated by reset_n so nothing is popped while reset is held.
  assign io_in_ready = (state_q == StIdle) & io_en & reset_n;
  assign accept      = io_in_valid & io_in_ready;

  // The shifter idles at all-ones and is refilled with ones, so txd is the
  // register bit itself and sits high between frames.
  assign io_txd  = shift_q[0];
  assign io_busy = (state_q == StShift);

  n101_uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .load_val   (io_div),
    .run        (io_busy),
    .reload_val (div_q),
    .tick       (bit_tick)
  );

  // Handshake FSM with shift register, bit counter and latched divisor.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      shift_q  <= '1;
      bitcnt_q <= '0;
      div_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // {stop, stop/fill, data, start}; the start bit leaves first.
            shift_q  <= {2'b11, io_in_bits, 1'b0};
            bitcnt_q <= uart_frame_len(io_nstop);
            div_q    <= io_div;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (bit_tick) begin
            shift_q  <= {1'b1, shift_q[ShiftW-1:1]};
            bitcnt_q <= bitcnt_q - 4'd1;
            if (bitcnt_q == 4'd1) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_n101_uart_tx.sv
// Self-checking bench for n101_uart_tx: a frame-level model predicts txd/busy/ready
// every cycle, and directed scenarios pin the model with literal expectations.
module tb_n101_uart_tx;

  logic        clock;
  logic        reset_n;
  logic        io_en;
  logic [15:0] io_div;
  logic        io_nstop;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_in_bits;
  logic        io_txd;
  logic        io_busy;

  n101_uart_tx dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .io_en       (io_en),
    .io_div      (io_div),
    .io_nstop    (io_nstop),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_bits  (io_in_bits),
    .io_txd      (io_txd),
    .io_busy     (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;
  int cyc;
  int dut_pops;
  bit chk_on;
  logic [7:0] q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Frame-level model: a frame is a list of bits, each held m_bitlen cycles.
  bit          m_active;
  int          m_t;
  int          m_len;
  int          m_bitlen;
  int          m_pops;
  logic [10:0] m_frame;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_bitlen <= 1;
    end else if (!m_active) begin
      if (io_en && io_in_valid) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_frame  <= {2'b11, io_in_bits, 1'b0};
        m_len    <= io_nstop ? 11 : 10;
        m_bitlen <= int'(io_div) + 1;
        m_pops   <= m_pops + 1;
      end
    end else begin
      if (m_t == m_len * m_bitlen) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_on) begin
      check("model_txd", 32'(io_txd),
            m_active ? 32'(m_frame[(m_t - 1) / m_bitlen]) : 32'd1);
      check("model_busy", 32'(io_busy), 32'(m_active));
      check("model_ready", 32'(io_in_ready), 32'(!m_active && io_en && reset_n));
    end
  end

  task automatic drive_src();
    io_in_valid = (q.size() != 0);
    io_in_bits  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: handshake sampled at negedge, applied after the posedge.
  task automatic step();
    logic r, v;
    @(negedge clock);
    r = io_in_ready;
    v = io_in_valid;
    @(posedge clock);
    #1;
    if (r && v && reset_n) begin
      dut_pops++;
      void'(q.pop_front());
    end
    drive_src();
  endtask

  task automatic wait_pop(input int max, output int t);
    int n0;
    n0 = dut_pops;
    t  = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (dut_pops != n0) begin
        t = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL pop_timeout: got no accept expected one within %0d cycles", max);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2, nb, n_before, k;
    logic [9:0] pat;

    reset_n     = 1'b0;
    io_en       = 1'b0;
    io_div      = 16'd3;
    io_nstop    = 1'b0;
    io_in_valid = 1'b0;
    io_in_bits  = 8'h00;
    chk_on      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_on = 1'b1;
    check("rst_txd", 32'(io_txd), 32'd1);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_ready", 32'(io_in_ready), 32'd0);
    io_en   = 1'b1;
    reset_n = 1'b1;
    step();
    check("post_rst_ready", 32'(io_in_ready), 32'd1);

    // Single frame 0xA5, div=3, 1 stop: bits 0,1,0,1,0,0,1,0,1,1 x4 cycles.
    pat = 10'b1101001010;
    q.push_back(8'hA5);
    drive_src();
    wait_pop(20, t);
    for (int i = 1; i <= 40; i++) begin
      check("a5_txd", 32'(io_txd), 32'(pat[(i - 1) / 4]));
      check("a5_busy", 32'(io_busy), 32'd1);
      step();
    end
    check("a5_ready_back", 32'(io_in_ready), 32'd1);
    check("a5_idle_txd", 32'(io_txd), 32'd1);

    // Two stop bits at div=0: one low cycle then ten high, ready at T+12.
    io_div   = 16'd0;
    io_nstop = 1'b1;
    q.push_back(8'hFF);
    drive_src();
    wait_pop(20, t);
    for (int i = 1; i <= 11; i++) begin
      check("ff_txd", 32'(io_txd), (i == 1) ? 32'd0 : 32'd1);
      check("ff_busy", 32'(io_busy), 32'd1);
      step();
    end
    check("ff_ready_back", 32'(io_in_ready), 32'd1);

    // Back-to-back 0x01, 0x80 at div=1: accepts exactly 21 cycles apart.
    io_div   = 16'd1;
    io_nstop = 1'b0;
    n_before = dut_pops;
    q.push_back(8'h01);
    q.push_back(8'h80);
    drive_src();
    wait_pop(20, t);
    wait_pop(40, t2);
    check("b2b_spacing", 32'(t2 - t), 32'd21);
    for (int i = 0; i < 40 && io_busy; i++) step();
    check("b2b_pops", 32'(dut_pops - n_before), 32'd2);

    // Drop enable and change divisor at T+10: frame keeps 4-cycle bits.
    io_div = 16'd3;
    q.push_back(8'h3C);
    drive_src();
    wait_pop(20, t);
    repeat (9) step();
    io_en  = 1'b0;
    io_div = 16'd7;
    n_before = dut_pops;
    q.push_back(8'hC3);
    drive_src();
    for (int j = 0; j <= 50; j++) begin
      if (j == 30) check("en0_busy_t40", 32'(io_busy), 32'd1);
      if (j == 31) check("en0_busy_t41", 32'(io_busy), 32'd0);
      step();
    end
    check("en0_no_accept", 32'(dut_pops), 32'(n_before));
    io_en = 1'b1;
    wait_pop(20, t);
    nb = 0;
    for (k = 0; k < 200 && io_busy; k++) begin
      nb++;
      step();
    end
    check("div7_frame_len", 32'(nb), 32'd80);

    // Valid held high through a frame: ready stays low, one pop per frame.
    io_div = 16'd3;
    q.push_back(8'h11);
    q.push_back(8'h22);
    drive_src();
    wait_pop(20, t);
    n_before = dut_pops;
    for (int i = 1; i <= 40; i++) begin
      check("busy_ready_low", 32'(io_in_ready), 32'd0);
      step();
    end
    check("busy_one_pop", 32'(dut_pops), 32'(n_before));
    check("busy_ready_t41", 32'(io_in_ready), 32'd1);
    wait_pop(20, t);
    for (int i = 0; i < 60 && io_busy; i++) step();

    // Reset mid-frame: outputs go idle without a clock edge.
    q.push_back(8'h5A);
    drive_src();
    wait_pop(20, t);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_txd", 32'(io_txd), 32'd1);
    check("async_rst_busy", 32'(io_busy), 32'd0);
    check("async_rst_ready", 32'(io_in_ready), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    check("rst_release_ready", 32'(io_in_ready), 32'd1);
    check("rst_release_txd", 32'(io_txd), 32'd1);

    // Randomized traffic with mid-frame config and enable changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0 && q.size() < 8) q.push_back(8'($urandom));
      if ($urandom_range(0, 29) == 0) io_en = ~io_en;
      if ($urandom_range(0, 19) == 0) begin
        io_div   = 16'($urandom_range(0, 3));
        io_nstop = 1'($urandom_range(0, 1));
      end
      drive_src();
      step();
    end
    io_en = 1'b1;
    for (int i = 0; i < 2000 && (q.size() != 0 || io_busy); i++) step();
    check("drain_empty", 32'(q.size()), 32'd0);
    step();
    check("pop_count", 32'(dut_pops), 32'(m_pops));

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
